lsu_ctrl: RTL and testbench

- Load/store unit: the initiator side of the data-memory port (we/addr/wdata/size/sign/rdata); dmem is the responder.
- Accepts one memory request at a time from the execute/memory stage over a valid/ready handshake.
- Aligned accesses go to dmem as one access. Misaligned accesses are split into sequential byte accesses, reassembled, then extended.
- Returns load data or a store acknowledge over a valid/ready response channel.

---
 rtl/lsu_ctrl_pkg.sv | 31 +++
 rtl/lsu_ctrl_if.sv | 49 ++++
 rtl/lsu_ctrl_extend.sv | 20 ++
 rtl/lsu_ctrl.sv | 155 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared load/store unit definitions: bus widths, dmem size encodings, LSU FSM states.
package lsu_ctrl_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int MEM_BYTES  = 4096;
  localparam int TAG_WIDTH  = 5;

  // Plain 2-bit type rather than an enum because 2'b11 is a legal encoding (treated as W).
  typedef logic [1:0] mem_read_size_t;

  localparam mem_read_size_t MEM_SIZE_B = 2'b00;
  localparam mem_read_size_t MEM_SIZE_H = 2'b01;
  localparam mem_read_size_t MEM_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ACCESS,
    LSU_SPLIT,
    LSU_RESP
  } lsu_state_t;

  function automatic logic [2:0] size_bytes(input mem_read_size_t size);
    case (size)
      MEM_SIZE_B: size_bytes = 3'd1;
      MEM_SIZE_H: size_bytes = 3'd2;
      default:    size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request/response channel between pipeline and LSU, and the LSU-to-dmem access port.
interface lsu_req_if;
  import lsu_ctrl_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  mem_read_size_t        req_size;
  logic                  req_sign;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic [TAG_WIDTH-1:0]  resp_tag;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_sign, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_tag, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_sign, req_tag, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_tag, resp_err
  );
endinterface

interface lsu_mem_if;
  import lsu_ctrl_pkg::*;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  mem_read_size_t        mem_size;
  logic                  mem_sign;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_we, mem_addr, mem_wdata, mem_size, mem_sign,
    input  mem_rdata
  );

  modport slave (
    input  mem_we, mem_addr, mem_wdata, mem_size, mem_sign,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_ctrl_extend.sv
// Masks raw load data to the access size and sign/zero extends it; shared with writeback.
module lsu_extend
  import lsu_ctrl_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] raw,
  input  mem_read_size_t        size,
  input  logic                  sign,
  output logic [DATA_WIDTH-1:0] data
);

  always_comb begin
    data = raw;
    case (size)
      MEM_SIZE_B: data = {{(DATA_WIDTH-8){sign & raw[7]}}, raw[7:0]};
      MEM_SIZE_H: data = {{(DATA_WIDTH-16){sign & raw[15]}}, raw[15:0]};
      default:    data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: one request at a time, aligned accesses in one dmem cycle,
// misaligned ones split into byte accesses and reassembled.
module lsu_ctrl #(
  parameter int MEM_BYTES = lsu_ctrl_pkg::MEM_BYTES,
  parameter int SPLIT_EN  = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  lsu_req_if.slave req_bus,
  lsu_mem_if.master mem_bus
);
  import lsu_ctrl_pkg::*;

  lsu_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  mem_read_size_t        size_q;
  logic                  sign_q;
  logic                  we_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [1:0]            k_q;
  logic [DATA_WIDTH-1:0] asm_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic [2:0]            req_nbytes;
  logic [2:0]            nbytes_q;
  logic [ADDR_WIDTH:0]   req_end;
  logic                  req_fault;
  logic                  req_misaligned;
  logic                  reject;
  logic                  accept;
  logic                  last_byte;
  logic [DATA_WIDTH-1:0] asm_next;
  logic [DATA_WIDTH-1:0] ext_raw;
  logic [DATA_WIDTH-1:0] ext_data;

  // End address carries one extra bit so a request wrapping past 2^ADDR_WIDTH still faults.
  assign req_nbytes     = size_bytes(req_bus.req_size);
  assign nbytes_q       = size_bytes(size_q);
  assign req_end        = {1'b0, req_bus.req_addr} + {{(ADDR_WIDTH-2){1'b0}}, req_nbytes};
  assign req_fault      = req_end > (ADDR_WIDTH+1)'(MEM_BYTES);
  assign req_misaligned = (req_bus.req_size == MEM_SIZE_H && req_bus.req_addr[0]) ||
                          (req_bus.req_size[1] && req_bus.req_addr[1:0] != 2'b00);
  assign reject         = req_fault || (req_misaligned && SPLIT_EN == 0);
  assign accept         = req_bus.req_valid && (state_q == LSU_IDLE);
  assign last_byte      = ({1'b0, k_q} == nbytes_q - 3'd1);

  always_comb begin
    asm_next = asm_q;
    asm_next[8*k_q +: 8] = mem_bus.mem_rdata[7:0];
  end

  assign ext_raw = (state_q == LSU_ACCESS) ? mem_bus.mem_rdata : asm_next;

  lsu_extend u_extend (
    .raw  (ext_raw),
    .size (size_q),
    .sign (sign_q),
    .data (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LSU_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus every handshake and dmem output, decoded from registered state only.
  always_comb begin
    state_d            = state_q;
    req_bus.req_ready  = 1'b0;
    req_bus.resp_valid = 1'b0;
    mem_bus.mem_we     = 1'b0;
    mem_bus.mem_addr   = '0;
    mem_bus.mem_wdata  = '0;
    mem_bus.mem_size   = MEM_SIZE_W;
    mem_bus.mem_sign   = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        req_bus.req_ready = 1'b1;
        if (accept) begin
          if (reject)              state_d = LSU_RESP;
          else if (req_misaligned) state_d = LSU_SPLIT;
          else                     state_d = LSU_ACCESS;
        end
      end
      LSU_ACCESS: begin
        mem_bus.mem_we    = we_q;
        mem_bus.mem_addr  = addr_q;
        mem_bus.mem_wdata = wdata_q;
        mem_bus.mem_size  = size_q;
        state_d           = LSU_RESP;
      end
      LSU_SPLIT: begin
        mem_bus.mem_we    = we_q;
        mem_bus.mem_addr  = addr_q + ADDR_WIDTH'(k_q);
        mem_bus.mem_wdata = {{(DATA_WIDTH-8){1'b0}}, wdata_q[8*k_q +: 8]};
        mem_bus.mem_size  = MEM_SIZE_B;
        if (last_byte) state_d = LSU_RESP;
      end
      LSU_RESP: begin
        req_bus.resp_valid = 1'b1;
        if (req_bus.resp_ready) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // Request latch, byte assembly and the response registers held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= MEM_SIZE_W;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      tag_q   <= '0;
      k_q     <= '0;
      asm_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (accept) begin
            addr_q  <= req_bus.req_addr;
            wdata_q <= req_bus.req_wdata;
            size_q  <= req_bus.req_size[1] ? MEM_SIZE_W : req_bus.req_size;
            sign_q  <= req_bus.req_sign;
            we_q    <= req_bus.req_we;
            tag_q   <= req_bus.req_tag;
            k_q     <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
            err_q   <= reject;
          end
        end
        LSU_ACCESS: begin
          rdata_q <= we_q ? '0 : ext_data;
        end
        LSU_SPLIT: begin
          asm_q <= asm_next;
          k_q   <= k_q + 2'd1;
          if (last_byte) rdata_q <= we_q ? '0 : ext_data;
        end
        default: ;
      endcase
    end
  end

  assign req_bus.resp_rdata = rdata_q;
  assign req_bus.resp_tag   = tag_q;
  assign req_bus.resp_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: byte-array dmem model, one task per scenario.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_req_if rq ();
  lsu_mem_if mm ();
  lsu_req_if rq2 ();
  lsu_mem_if mm2 ();

  lsu_ctrl #(.MEM_BYTES(4096), .SPLIT_EN(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_bus (rq.slave),
    .mem_bus (mm.master)
  );

  lsu_ctrl #(.MEM_BYTES(4096), .SPLIT_EN(0)) dut_nosplit (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_bus (rq2.slave),
    .mem_bus (mm2.master)
  );

  logic [7:0] mem [0:4095];
  int wr_cnt = 0;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int mm2_we_seen = 0;

  assign mm.mem_rdata = {mem[mm.mem_addr[11:0] + 12'd3], mem[mm.mem_addr[11:0] + 12'd2],
                         mem[mm.mem_addr[11:0] + 12'd1], mem[mm.mem_addr[11:0]]};
  assign mm2.mem_rdata = '0;

  // dmem write model; byte lanes follow mem_size with the data LSB-aligned.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mm2.mem_we) mm2_we_seen = mm2_we_seen + 1;
    if (mm.mem_we) begin
      wr_cnt = wr_cnt + 1;
      mem[mm.mem_addr[11:0]] = mm.mem_wdata[7:0];
      if (mm.mem_size != MEM_SIZE_B) mem[mm.mem_addr[11:0] + 12'd1] = mm.mem_wdata[15:8];
      if (mm.mem_size[1]) begin
        mem[mm.mem_addr[11:0] + 12'd2] = mm.mem_wdata[23:16];
        mem[mm.mem_addr[11:0] + 12'd3] = mm.mem_wdata[31:24];
      end
    end
  end

  logic [31:0] obs_addr [8];
  logic [31:0] obs_wdata [8];
  logic [1:0]  obs_size [8];
  logic        obs_we [8];
  int          nobs;
  int          lat;
  int          acc_cyc;
  logic [31:0] r_data;
  logic [4:0]  r_tag;
  logic        r_err;

  // Issues one request from an IDLE cycle, records the dmem bus each cycle, returns at the
  // first negedge with resp_valid high (not consumed). lat=-1 means no response arrived.
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic sign, input logic [4:0] tag);
    rq.req_we    = we;
    rq.req_addr  = addr;
    rq.req_wdata = wdata;
    rq.req_size  = size;
    rq.req_sign  = sign;
    rq.req_tag   = tag;
    rq.req_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    rq.req_valid = 1'b0;
    nobs = 0;
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rq.resp_valid) break;
      if (nobs < 8) begin
        obs_addr[nobs]  = mm.mem_addr;
        obs_wdata[nobs] = mm.mem_wdata;
        obs_size[nobs]  = mm.mem_size;
        obs_we[nobs]    = mm.mem_we;
      end
      nobs++;
      lat++;
    end
    if (!rq.resp_valid) lat = -1;
    r_data = rq.resp_rdata;
    r_tag  = rq.resp_tag;
    r_err  = rq.resp_err;
  endtask

  task automatic consume();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (mm.mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_we: got %b expected 0", mm.mem_we); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if ({rq.req_ready, rq.resp_valid} !== 2'b10) begin n_fail++; $display("[TB] FAIL reset_handshake: ready/valid got %b%b expected 10", rq.req_ready, rq.resp_valid); end
    n_checks++; if ({mm.mem_addr, mm.mem_wdata, mm.mem_size, mm.mem_sign} !== {32'h0, 32'h0, 2'b10, 1'b0}) begin n_fail++; $display("[TB] FAIL reset_mem_bus: addr=%h wdata=%h size=%b sign=%b expected 0/0/10/0", mm.mem_addr, mm.mem_wdata, mm.mem_size, mm.mem_sign); end
    n_checks++; if ({rq.resp_rdata, rq.resp_tag, rq.resp_err} !== 38'h0) begin n_fail++; $display("[TB] FAIL reset_resp_regs: rdata=%h tag=%0d err=%b expected zeros", rq.resp_rdata, rq.resp_tag, rq.resp_err); end
  endtask

  task automatic test_aligned_load();
    int wr0;
    mem[12'h010] = 8'h78; mem[12'h011] = 8'h56; mem[12'h012] = 8'h34; mem[12'h013] = 8'h12;
    wr0 = wr_cnt;
    run_req(1'b0, 32'h10, 32'h0, MEM_SIZE_W, 1'b0, 5'd5);
    n_checks++; if (lat !== 2) begin n_fail++; $display("[TB] FAIL aligned_load_latency: got %0d expected 2", lat); end
    n_checks++; if ({r_data, r_tag, r_err} !== {32'h12345678, 5'd5, 1'b0}) begin n_fail++; $display("[TB] FAIL aligned_load_resp: rdata=%h tag=%0d err=%b expected 12345678/5/0", r_data, r_tag, r_err); end
    n_checks++; if ({nobs[3:0], obs_addr[0], obs_size[0], obs_we[0]} !== {4'd1, 32'h10, 2'b10, 1'b0}) begin n_fail++; $display("[TB] FAIL aligned_load_bus: cycles=%0d addr=%h size=%b we=%b expected 1/10/10/0", nobs, obs_addr[0], obs_size[0], obs_we[0]); end
    consume();
    n_checks++; if (wr_cnt !== wr0) begin n_fail++; $display("[TB] FAIL aligned_load_no_write: writes=%0d expected %0d", wr_cnt, wr0); end
  endtask

  task automatic test_sign_extend();
    mem[12'h020] = 8'h80;
    mem[12'h030] = 8'h34; mem[12'h031] = 8'h92; mem[12'h032] = 8'hF0;
    run_req(1'b0, 32'h20, 32'h0, MEM_SIZE_B, 1'b1, 5'd1);
    n_checks++; if (r_data !== 32'hFFFFFF80) begin n_fail++; $display("[TB] FAIL byte_signed: got %h expected FFFFFF80", r_data); end
    consume();
    run_req(1'b0, 32'h20, 32'h0, MEM_SIZE_B, 1'b0, 5'd2);
    n_checks++; if (r_data !== 32'h00000080) begin n_fail++; $display("[TB] FAIL byte_unsigned: got %h expected 00000080", r_data); end
    consume();
    run_req(1'b0, 32'h30, 32'h0, MEM_SIZE_H, 1'b1, 5'd3);
    n_checks++; if ({lat[3:0], r_data} !== {4'd2, 32'hFFFF9234}) begin n_fail++; $display("[TB] FAIL half_signed: lat=%0d data=%h expected 2/FFFF9234", lat, r_data); end
    consume();
    run_req(1'b0, 32'h31, 32'h0, MEM_SIZE_H, 1'b1, 5'd4);
    n_checks++; if ({lat[3:0], r_data} !== {4'd3, 32'hFFFFF092}) begin n_fail++; $display("[TB] FAIL half_misaligned_signed: lat=%0d data=%h expected 3/FFFFF092", lat, r_data); end
    consume();
  endtask

  task automatic test_split_store();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hDD; exp_b[1] = 8'hCC; exp_b[2] = 8'hBB; exp_b[3] = 8'hAA;
    run_req(1'b1, 32'h21, 32'hAABBCCDD, MEM_SIZE_W, 1'b0, 5'd6);
    n_checks++; if ({lat[3:0], r_data, r_tag, r_err} !== {4'd5, 32'h0, 5'd6, 1'b0}) begin n_fail++; $display("[TB] FAIL split_store_resp: lat=%0d rdata=%h tag=%0d err=%b expected 5/0/6/0", lat, r_data, r_tag, r_err); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({obs_addr[i], obs_wdata[i], obs_size[i], obs_we[i]} !== {32'h21 + 32'(i), 24'h0, exp_b[i], 2'b00, 1'b1}) begin n_fail++; $display("[TB] FAIL split_store_byte%0d: addr=%h wdata=%h size=%b we=%b expected %h/%h/00/1", i, obs_addr[i], obs_wdata[i], obs_size[i], obs_we[i], 32'h21 + 32'(i), exp_b[i]); end
    end
    consume();
    run_req(1'b0, 32'h21, 32'h0, MEM_SIZE_W, 1'b0, 5'd7);
    n_checks++; if ({lat[3:0], r_data} !== {4'd5, 32'hAABBCCDD}) begin n_fail++; $display("[TB] FAIL split_load_back: lat=%0d data=%h expected 5/AABBCCDD", lat, r_data); end
    consume();
  endtask

  task automatic test_fault();
    int wr0;
    wr0 = wr_cnt;
    run_req(1'b0, 32'hFFE, 32'h0, MEM_SIZE_W, 1'b0, 5'd8);
    n_checks++; if ({lat[3:0], r_data, r_err} !== {4'd1, 32'h0, 1'b1}) begin n_fail++; $display("[TB] FAIL fault_load: lat=%0d rdata=%h err=%b expected 1/0/1", lat, r_data, r_err); end
    consume();
    run_req(1'b1, 32'hFFE, 32'h55667788, MEM_SIZE_W, 1'b0, 5'd9);
    consume();
    n_checks++; if ({r_err, 32'(wr_cnt - wr0)} !== {1'b1, 32'd0}) begin n_fail++; $display("[TB] FAIL fault_store: err=%b writes=%0d expected 1/0", r_err, wr_cnt - wr0); end
    run_req(1'b0, 32'hFFC, 32'h0, MEM_SIZE_W, 1'b0, 5'd10);
    n_checks++; if ({lat[3:0], r_err} !== {4'd2, 1'b0}) begin n_fail++; $display("[TB] FAIL edge_in_range: lat=%0d err=%b expected 2/0", lat, r_err); end
    consume();
    run_req(1'b0, 32'hFFFFFFFF, 32'h0, MEM_SIZE_B, 1'b0, 5'd11);
    n_checks++; if ({lat[3:0], r_err} !== {4'd1, 1'b1}) begin n_fail++; $display("[TB] FAIL wrap_fault: lat=%0d err=%b expected 1/1", lat, r_err); end
    consume();
  endtask

  task automatic test_nosplit();
    rq2.req_we = 1'b0; rq2.req_addr = 32'h3; rq2.req_size = MEM_SIZE_H; rq2.req_tag = 5'd7;
    rq2.req_valid = 1'b1;
    @(posedge clk);
    #1;
    rq2.req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({rq2.resp_valid, rq2.resp_err, rq2.resp_rdata, rq2.resp_tag} !== {1'b1, 1'b1, 32'h0, 5'd7}) begin n_fail++; $display("[TB] FAIL nosplit_misaligned: valid=%b err=%b rdata=%h tag=%0d expected 1/1/0/7", rq2.resp_valid, rq2.resp_err, rq2.resp_rdata, rq2.resp_tag); end
    consume();
    n_checks++; if ({rq2.req_ready, mm2_we_seen[3:0]} !== {1'b1, 4'd0}) begin n_fail++; $display("[TB] FAIL nosplit_idle: ready=%b mem_we_cycles=%0d expected 1/0", rq2.req_ready, mm2_we_seen); end
  endtask

  task automatic test_backpressure();
    rq.resp_ready = 1'b0;
    run_req(1'b0, 32'h10, 32'h0, MEM_SIZE_W, 1'b0, 5'd9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if ({rq.resp_valid, rq.req_ready, rq.resp_tag, rq.resp_rdata} !== {1'b1, 1'b0, 5'd9, 32'h12345678}) begin n_fail++; $display("[TB] FAIL backpressure_hold%0d: valid=%b ready=%b tag=%0d rdata=%h expected 1/0/9/12345678", i, rq.resp_valid, rq.req_ready, rq.resp_tag, rq.resp_rdata); end
    end
    #1;
    rq.resp_ready = 1'b1;
    consume();
    n_checks++; if ({rq.resp_valid, rq.req_ready} !== 2'b01) begin n_fail++; $display("[TB] FAIL backpressure_release: valid=%b ready=%b expected 0/1", rq.resp_valid, rq.req_ready); end
  endtask

  task automatic test_back_to_back();
    int first_acc;
    run_req(1'b0, 32'h10, 32'h0, MEM_SIZE_W, 1'b0, 5'd12);
    first_acc = acc_cyc;
    consume();
    run_req(1'b0, 32'h30, 32'h0, MEM_SIZE_H, 1'b0, 5'd13);
    n_checks++; if ({32'(acc_cyc - first_acc), r_data, r_tag} !== {32'd3, 32'h00009234, 5'd13}) begin n_fail++; $display("[TB] FAIL back_to_back: spacing=%0d data=%h tag=%0d expected 3/00009234/13", acc_cyc - first_acc, r_data, r_tag); end
    consume();
  endtask

  task automatic test_reset_mid_split();
    int wr0;
    mem[12'h041] = 8'h00; mem[12'h042] = 8'h00; mem[12'h043] = 8'h00; mem[12'h044] = 8'h00;
    wr0 = wr_cnt;
    rq.req_we = 1'b1; rq.req_addr = 32'h41; rq.req_wdata = 32'h11223344;
    rq.req_size = MEM_SIZE_W; rq.req_tag = 5'd14; rq.req_valid = 1'b1;
    @(posedge clk);
    #1;
    rq.req_valid = 1'b0;
    @(posedge clk);
    #2;
    n_checks++; if ({mm.mem_we, mm.mem_addr} !== {1'b1, 32'h42}) begin n_fail++; $display("[TB] FAIL mid_split_byte1: we=%b addr=%h expected 1/42", mm.mem_we, mm.mem_addr); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({mm.mem_we, rq.req_ready, rq.resp_valid} !== 3'b010) begin n_fail++; $display("[TB] FAIL mid_split_async: we=%b ready=%b valid=%b expected 0/1/0", mm.mem_we, rq.req_ready, rq.resp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if ({rq.req_ready, rq.resp_valid} !== 2'b10) begin n_fail++; $display("[TB] FAIL mid_split_after: ready=%b valid=%b expected 1/0", rq.req_ready, rq.resp_valid); end
    n_checks++; if ({mem[12'h041], mem[12'h042], mem[12'h043], 32'(wr_cnt - wr0)} !== {8'h44, 8'h00, 8'h00, 32'd1}) begin n_fail++; $display("[TB] FAIL mid_split_mem: bytes=%h %h %h writes=%0d expected 44 00 00/1", mem[12'h041], mem[12'h042], mem[12'h043], wr_cnt - wr0); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    rq.req_valid = 1'b0; rq.req_we = 1'b0; rq.req_addr = '0; rq.req_wdata = '0;
    rq.req_size = MEM_SIZE_W; rq.req_sign = 1'b0; rq.req_tag = '0; rq.resp_ready = 1'b1;
    rq2.req_valid = 1'b0; rq2.req_we = 1'b0; rq2.req_addr = '0; rq2.req_wdata = '0;
    rq2.req_size = MEM_SIZE_W; rq2.req_sign = 1'b0; rq2.req_tag = '0; rq2.resp_ready = 1'b1;
    test_reset();
    test_aligned_load();
    test_sign_extend();
    test_split_store();
    test_fault();
    test_nosplit();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_split();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
